ysyx_22050518_lsu: RTL and testbench

- Load/store unit that sits directly upstream of the data-memory stage.
- Accepts one memory op at a time from execute via a valid/ready handshake, drives the memory port, and extends, shifts and merges load data.
- Splits 8-byte-boundary-crossing accesses into two memory accesses.
- Returns result plus difftest skip flag to writeback via a valid/ready handshake.

---
 rtl/ysyx_22050518_lsu_pkg.sv | 41 ++++
 rtl/ysyx_22050518_lsu_ext.sv | 53 +++++
 rtl/ysyx_22050518_lsu.sv | 211 +++++++++++++++++++++
 tb/tb_ysyx_22050518_lsu.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050518_lsu_pkg.sv
// ysyx_22050518_lsu_pkg
// Shared definitions for the load/store unit:
//   - funct3 encodings for loads (LB..LWU) and stores (SB..SD)
//   - FSM state enum used by the top level
//   - size_bytes(): access size in bytes from the low two funct3 bits
package ysyx_22050518_lsu_pkg;

    // Load encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP,
        ST_ERR
    } state_t;

    // Byte count for a size code (funct3[1:0]): 1, 2, 4 or 8
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050518_lsu_ext.sv
// ysyx_22050518_lsu_ext
// Combinational load-data formatter: shifts the addressed bytes down to
// bit 0, merges in the bytes from the following word when the access
// crosses an 8-byte boundary, truncates to the access size and sign- or
// zero-extends per funct3.
// Ports:
//   word0  - memory word holding the first byte of the access
//   word1  - following memory word (only used when the access crosses)
//   off    - byte offset of the access inside word0
//   funct3 - RISC-V load funct3 (size and signedness)
//   data   - extended load result (0 for an illegal funct3)
module ysyx_22050518_lsu_ext
    import ysyx_22050518_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] word0,
    input  logic [XLEN-1:0] word1,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [3:0]      n;
    logic [3:0]      n0;
    logic            split;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] field;

    // Assemble the raw field, then extend according to funct3.
    // n0 can be 8 (off == 0); a 64-bit shift then yields 0, but word1 is
    // masked anyway because such an access never crosses.
    always_comb begin
        n     = size_bytes(funct3[1:0]);
        n0    = 4'd8 - {1'b0, off};
        split = ({1'b0, off} + n) > 4'd8;
        lo    = word0 >> {off, 3'b000};
        hi    = split ? (word1 << {n0, 3'b000}) : '0;
        field = lo | hi;
        case (funct3)
            LB:      data = {{(XLEN-8){field[7]}}, field[7:0]};
            LH:      data = {{(XLEN-16){field[15]}}, field[15:0]};
            LW:      data = {{(XLEN-32){field[31]}}, field[31:0]};
            LD:      data = field;
            LBU:     data = {{(XLEN-8){1'b0}}, field[7:0]};
            LHU:     data = {{(XLEN-16){1'b0}}, field[15:0]};
            LWU:     data = {{(XLEN-32){1'b0}}, field[31:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050518_lsu.sv
// ysyx_22050518_lsu
// Load/store unit between execute and the data memory. Takes one op at a
// time, drives the memory port for one or two accesses, formats load data
// and hands the result plus a difftest skip flag to writeback.
// Configuration macro: YSYX_22050518_LSU_MISALIGN_EN
//   defined   - accesses crossing an 8-byte boundary are split in two
//   undefined - such accesses are rejected with resp_err
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   req_valid/req_ready          - request handshake from execute
//   req_wen, req_funct3          - store flag and size/sign code
//   req_addr, req_wdata          - byte address and LSB-aligned store data
//   resp_valid/resp_ready        - result handshake to writeback
//   resp_data, resp_err          - load result, illegal/misaligned flag
//   resp_skip_ref                - OR of mem_skip_ref over the op
//   mem_en, mem_r_addr, mem_r_data                 - read side (aligned)
//   mem_w_en, mem_w_addr, mem_w_width, mem_w_data  - write side
//   mem_skip_ref                 - memory marks access as MMIO/skip
module ysyx_22050518_lsu
    import ysyx_22050518_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [2:0]      req_funct3,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            resp_skip_ref,
    output logic            mem_en,
    output logic [AW-1:0]   mem_r_addr,
    input  logic [XLEN-1:0] mem_r_data,
    output logic            mem_w_en,
    output logic [AW-1:0]   mem_w_addr,
    output logic [3:0]      mem_w_width,
    output logic [XLEN-1:0] mem_w_data,
    input  logic            mem_skip_ref
);

    state_t          state;
    logic [2:0]      funct3_q;
    logic [2:0]      off_q;

    logic [3:0]      req_n;
    logic            req_cross;
    logic            req_illegal;
    logic            req_bad;

    logic [XLEN-1:0] ext_word0;
    logic [XLEN-1:0] ext_word1;
    logic [XLEN-1:0] ext_data;

`ifdef YSYX_22050518_LSU_MISALIGN_EN
    logic            split_q;
    logic [XLEN-1:0] word0_q;
    logic [3:0]      req_n0;
    logic [3:0]      cur_n0;
    logic [3:0]      cur_n1;
`endif

    // Decode the incoming request: size, boundary crossing, legality.
    always_comb begin
        req_n       = size_bytes(req_funct3[1:0]);
        req_cross   = ({1'b0, req_addr[2:0]} + req_n) > 4'd8;
        req_illegal = req_wen ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef YSYX_22050518_LSU_MISALIGN_EN
        req_bad     = req_illegal;
        req_n0      = 4'd8 - {1'b0, req_addr[2:0]};
        cur_n0      = 4'd8 - {1'b0, off_q};
        cur_n1      = size_bytes(funct3_q[1:0]) - cur_n0;
`else
        req_bad     = req_illegal | req_cross;
`endif
    end

`ifdef YSYX_22050518_LSU_MISALIGN_EN
    // In ACC1 the first word comes from the capture register and the live
    // memory data is the second word.
    assign ext_word0 = (state == ST_ACC1) ? word0_q : mem_r_data;
    assign ext_word1 = mem_r_data;
`else
    assign ext_word0 = mem_r_data;
    assign ext_word1 = '0;
`endif

    ysyx_22050518_lsu_ext #(
        .XLEN (XLEN)
    ) u_ext (
        .word0  (ext_word0),
        .word1  (ext_word1),
        .off    (off_q),
        .funct3 (funct3_q),
        .data   (ext_data)
    );

    // Main FSM with registered memory and response outputs.
    // mem_w_en doubles as the latched store flag while an access is in
    // flight, mem_r_addr as the aligned base address and mem_w_data as the
    // store data, so part 1 is derived from the part-0 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_skip_ref <= 1'b0;
            resp_data     <= '0;
            mem_en        <= 1'b0;
            mem_w_en      <= 1'b0;
            mem_r_addr    <= '0;
            mem_w_addr    <= '0;
            mem_w_width   <= '0;
            mem_w_data    <= '0;
            funct3_q      <= '0;
            off_q         <= '0;
`ifdef YSYX_22050518_LSU_MISALIGN_EN
            split_q       <= 1'b0;
            word0_q       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready     <= 1'b0;
                        resp_skip_ref <= 1'b0;
                        resp_err      <= 1'b0;
                        resp_data     <= '0;
                        funct3_q      <= req_funct3;
                        off_q         <= req_addr[2:0];
                        if (req_bad) begin
                            state      <= ST_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state      <= ST_ACC0;
                            mem_en     <= 1'b1;
                            mem_w_en   <= req_wen;
                            mem_r_addr <= {req_addr[AW-1:3], 3'b000};
                            mem_w_addr <= req_addr;
                            mem_w_data <= req_wdata;
`ifdef YSYX_22050518_LSU_MISALIGN_EN
                            split_q     <= req_cross;
                            mem_w_width <= req_cross ? req_n0 : req_n;
`else
                            mem_w_width <= req_n;
`endif
                        end
                    end
                end

                ST_ACC0: begin
                    resp_skip_ref <= resp_skip_ref | mem_skip_ref;
`ifdef YSYX_22050518_LSU_MISALIGN_EN
                    if (split_q) begin
                        state       <= ST_ACC1;
                        word0_q     <= mem_r_data;
                        mem_r_addr  <= mem_r_addr + AW'(8);
                        mem_w_addr  <= mem_r_addr + AW'(8);
                        mem_w_width <= cur_n1;
                        mem_w_data  <= mem_w_data >> {cur_n0, 3'b000};
                    end else begin
`else
                    begin
`endif
                        state      <= ST_RESP;
                        mem_en     <= 1'b0;
                        mem_w_en   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= mem_w_en ? '0 : ext_data;
                    end
                end

`ifdef YSYX_22050518_LSU_MISALIGN_EN
                ST_ACC1: begin
                    state         <= ST_RESP;
                    mem_en        <= 1'b0;
                    mem_w_en      <= 1'b0;
                    resp_valid    <= 1'b1;
                    resp_skip_ref <= resp_skip_ref | mem_skip_ref;
                    resp_data     <= mem_w_en ? '0 : ext_data;
                end
`endif

                ST_RESP, ST_ERR: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_en     <= 1'b0;
                    mem_w_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_lsu.sv
// tb_ysyx_22050518_lsu
// Directed bench for the load/store unit: a table of single-op vectors with
// hand-computed results, plus sequences for writeback stall with skip flag,
// reset in the middle of an op, and the reset state.
// Follows YSYX_22050518_LSU_MISALIGN_EN for the expected split behaviour.
module tb_ysyx_22050518_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        resp_skip_ref;
    logic        mem_en;
    logic [63:0] mem_r_addr;
    logic [63:0] mem_r_data;
    logic        mem_w_en;
    logic [63:0] mem_w_addr;
    logic [3:0]  mem_w_width;
    logic [63:0] mem_w_data;
    logic        mem_skip_ref;

    ysyx_22050518_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .resp_skip_ref (resp_skip_ref),
        .mem_en        (mem_en),
        .mem_r_addr    (mem_r_addr),
        .mem_r_data    (mem_r_data),
        .mem_w_en      (mem_w_en),
        .mem_w_addr    (mem_w_addr),
        .mem_w_width   (mem_w_width),
        .mem_w_data    (mem_w_data),
        .mem_skip_ref  (mem_skip_ref)
    );

    always #5 clk = ~clk;

    // Two-word memory model around the aligned address of the current op
    logic [63:0] tb_addr0;
    logic [63:0] tb_word0;
    logic [63:0] tb_word1;
    logic        tb_skip;

    assign mem_r_data   = (mem_r_addr == tb_addr0)         ? tb_word0 :
                          (mem_r_addr == tb_addr0 + 64'd8) ? tb_word1 :
                                                             64'hDEAD_BEEF_DEAD_BEEF;
    assign mem_skip_ref = tb_skip & mem_en;

    // Access log sampled mid-cycle
    logic [63:0] rd_log [4];
    logic [63:0] wa_log [4];
    logic [3:0]  ww_log [4];
    logic [63:0] wd_log [4];
    int          n_rd;
    int          n_wr;

    always @(negedge clk) begin
        if (mem_en) begin
            if (n_rd < 4) rd_log[n_rd] = mem_r_addr;
            n_rd = n_rd + 1;
            if (mem_w_en) begin
                if (n_wr < 4) begin
                    wa_log[n_wr] = mem_w_addr;
                    ww_log[n_wr] = mem_w_width;
                    wd_log[n_wr] = mem_w_data;
                end
                n_wr = n_wr + 1;
            end
        end
    end

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] w0;
        logic [63:0] w1;
        logic        skip;
        logic        e_err;
        logic [63:0] e_data;
        int          e_lat;
        int          e_nacc;
        int          e_nwr;
        logic [63:0] e_wa0;
        logic [3:0]  e_ww0;
        logic [63:0] e_wd0;
        logic [63:0] e_wa1;
        logic [3:0]  e_ww1;
        logic [63:0] e_wd1;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mkLoad(input logic [2:0] f3, input logic [63:0] addr,
                                    input logic [63:0] w0, input logic [63:0] w1,
                                    input logic err, input logic [63:0] data,
                                    input int lat, input int nacc);
        vec_t v;
        v.wen = 1'b0; v.f3 = f3; v.addr = addr; v.wdata = 64'h0;
        v.w0 = w0; v.w1 = w1; v.skip = 1'b0;
        v.e_err = err; v.e_data = data; v.e_lat = lat; v.e_nacc = nacc; v.e_nwr = 0;
        v.e_wa0 = 64'h0; v.e_ww0 = 4'h0; v.e_wd0 = 64'h0;
        v.e_wa1 = 64'h0; v.e_ww1 = 4'h0; v.e_wd1 = 64'h0;
        return v;
    endfunction

    function automatic vec_t mkStore(input logic [2:0] f3, input logic [63:0] addr,
                                     input logic [63:0] wdata, input logic err,
                                     input int lat, input int nacc, input int nwr,
                                     input logic [63:0] wa0, input logic [3:0] ww0,
                                     input logic [63:0] wd0, input logic [63:0] wa1,
                                     input logic [3:0] ww1, input logic [63:0] wd1);
        vec_t v;
        v.wen = 1'b1; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.w0 = 64'h0; v.w1 = 64'h0; v.skip = 1'b0;
        v.e_err = err; v.e_data = 64'h0; v.e_lat = lat; v.e_nacc = nacc; v.e_nwr = nwr;
        v.e_wa0 = wa0; v.e_ww0 = ww0; v.e_wd0 = wd0;
        v.e_wa1 = wa1; v.e_ww1 = ww1; v.e_wd1 = wd1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one request (called at a negedge with the LSU idle) and wait,
    // bounded, for resp_valid. lat counts clock edges from the accept edge.
    task automatic applyStimulus(input vec_t v, output int lat, output logic busy_ready);
        tb_addr0   = {v.addr[63:3], 3'b000};
        tb_word0   = v.w0;
        tb_word1   = v.w1;
        tb_skip    = v.skip;
        n_rd       = 0;
        n_wr       = 0;
        req_wen    = v.wen;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        lat        = 0;
        busy_ready = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready) busy_ready = 1'b1;
        end while (!resp_valid && lat < 10);
    endtask

    task automatic releaseResp(input string tag, input int nacc, input int nwr);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, " resp_valid after release"}, resp_valid, 1'b0);
        checkOutput({tag, " req_ready after release"}, req_ready, 1'b1);
        checkOutput({tag, " access count"}, n_rd, nacc);
        checkOutput({tag, " write count"}, n_wr, nwr);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   lat;
        logic busy;
        vec_t v;
        string tag;

        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0;
        req_addr = 64'h0; req_wdata = 64'h0; resp_ready = 1'b0;
        tb_addr0 = 64'h0; tb_word0 = 64'h0; tb_word1 = 64'h0; tb_skip = 1'b0;
        n_rd = 0; n_wr = 0;

        // Loads: f3, addr, word0, word1, err, data, latency, accesses
        vecs.push_back(mkLoad(3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h1122_3344_5566_7788, 2, 1));
        vecs.push_back(mkLoad(3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1));
        vecs.push_back(mkLoad(3'b100, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0, 1'b0, 64'h0000_0000_0000_0080, 2, 1));
`ifdef YSYX_22050518_LSU_MISALIGN_EN
        vecs.push_back(mkLoad(3'b010, 64'h8000_0006, 64'hBBAA_0000_0000_0000, 64'h0000_0000_0000_DDCC, 1'b0, 64'hFFFF_FFFF_DDCC_BBAA, 3, 2));
`else
        vecs.push_back(mkLoad(3'b010, 64'h8000_0006, 64'hBBAA_0000_0000_0000, 64'h0000_0000_0000_DDCC, 1'b1, 64'h0, 1, 0));
`endif
        vecs.push_back(mkLoad(3'b001, 64'h8000_0002, 64'h0000_0000_8765_4321, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_8765, 2, 1));
        vecs.push_back(mkLoad(3'b101, 64'h8000_0002, 64'h0000_0000_8765_4321, 64'h0, 1'b0, 64'h0000_0000_0000_8765, 2, 1));
        vecs.push_back(mkLoad(3'b110, 64'h8000_0004, 64'hCAFE_BABE_0000_0000, 64'h0, 1'b0, 64'h0000_0000_CAFE_BABE, 2, 1));
        vecs.push_back(mkLoad(3'b010, 64'h8000_0004, 64'hCAFE_BABE_0000_0000, 64'h0, 1'b0, 64'hFFFF_FFFF_CAFE_BABE, 2, 1));
`ifdef YSYX_22050518_LSU_MISALIGN_EN
        vecs.push_back(mkLoad(3'b101, 64'h8000_0107, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 1'b0, 64'h0000_0000_0000_CDAB, 3, 2));
`else
        vecs.push_back(mkLoad(3'b101, 64'h8000_0107, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 1'b1, 64'h0, 1, 0));
`endif
        vecs.push_back(mkLoad(3'b111, 64'h8000_0000, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 64'h0, 1, 0));

        // Stores: f3, addr, wdata, err, latency, accesses, writes, write0, write1
        vecs.push_back(mkStore(3'b100, 64'h8000_0000, 64'h1111_2222_3333_4444, 1'b1, 1, 0, 0,
                               64'h0, 4'd0, 64'h0, 64'h0, 4'd0, 64'h0));
        vecs.push_back(mkStore(3'b000, 64'h8000_0005, 64'h1234_5678_9ABC_DE5A, 1'b0, 2, 1, 1,
                               64'h8000_0005, 4'd1, 64'h1234_5678_9ABC_DE5A, 64'h0, 4'd0, 64'h0));
        vecs.push_back(mkStore(3'b010, 64'h8000_0010, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 2, 1, 1,
                               64'h8000_0010, 4'd4, 64'hFFFF_FFFF_CAFE_F00D, 64'h0, 4'd0, 64'h0));
`ifdef YSYX_22050518_LSU_MISALIGN_EN
        vecs.push_back(mkStore(3'b011, 64'h8000_000C, 64'h0807_0605_0403_0201, 1'b0, 3, 2, 2,
                               64'h8000_000C, 4'd4, 64'h0807_0605_0403_0201,
                               64'h8000_0010, 4'd4, 64'h0000_0000_0807_0605));
        vecs.push_back(mkStore(3'b001, 64'h8000_0007, 64'h0000_0000_0000_1234, 1'b0, 3, 2, 2,
                               64'h8000_0007, 4'd1, 64'h0000_0000_0000_1234,
                               64'h8000_0008, 4'd1, 64'h0000_0000_0000_0012));
`else
        vecs.push_back(mkStore(3'b011, 64'h8000_000C, 64'h0807_0605_0403_0201, 1'b1, 1, 0, 0,
                               64'h0, 4'd0, 64'h0, 64'h0, 4'd0, 64'h0));
        vecs.push_back(mkStore(3'b001, 64'h8000_0007, 64'h0000_0000_0000_1234, 1'b1, 1, 0, 0,
                               64'h0, 4'd0, 64'h0, 64'h0, 4'd0, 64'h0));
`endif

        // Reset state, both during and after reset
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", req_ready, 1'b1);
        checkOutput("reset resp_valid", resp_valid, 1'b0);
        checkOutput("reset mem_en", mem_en, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset req_ready", req_ready, 1'b1);
        checkOutput("post-reset resp_valid", resp_valid, 1'b0);
        checkOutput("post-reset resp_err", resp_err, 1'b0);
        checkOutput("post-reset resp_skip_ref", resp_skip_ref, 1'b0);
        checkOutput("post-reset resp_data", resp_data, 64'h0);
        checkOutput("post-reset mem_w_en", mem_w_en, 1'b0);

        // Table-driven single ops
        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("v%0d", i);
            applyStimulus(vecs[i], lat, busy);
            checkOutput({tag, " latency"}, lat, vecs[i].e_lat);
            checkOutput({tag, " resp_valid"}, resp_valid, 1'b1);
            checkOutput({tag, " resp_err"}, resp_err, vecs[i].e_err);
            checkOutput({tag, " resp_data"}, resp_data, vecs[i].e_data);
            checkOutput({tag, " resp_skip_ref"}, resp_skip_ref, vecs[i].skip);
            checkOutput({tag, " req_ready while busy"}, busy, 1'b0);
            if (vecs[i].e_nacc >= 1)
                checkOutput({tag, " read addr 0"}, rd_log[0], {vecs[i].addr[63:3], 3'b000});
            if (vecs[i].e_nacc >= 2)
                checkOutput({tag, " read addr 1"}, rd_log[1], {vecs[i].addr[63:3], 3'b000} + 64'd8);
            if (vecs[i].e_nwr >= 1) begin
                checkOutput({tag, " write0 addr"}, wa_log[0], vecs[i].e_wa0);
                checkOutput({tag, " write0 width"}, ww_log[0], vecs[i].e_ww0);
                checkOutput({tag, " write0 data"}, wd_log[0], vecs[i].e_wd0);
            end
            if (vecs[i].e_nwr >= 2) begin
                checkOutput({tag, " write1 addr"}, wa_log[1], vecs[i].e_wa1);
                checkOutput({tag, " write1 width"}, ww_log[1], vecs[i].e_ww1);
                checkOutput({tag, " write1 data"}, wd_log[1], vecs[i].e_wd1);
            end
            releaseResp(tag, vecs[i].e_nacc, vecs[i].e_nwr);
        end

        // MMIO load with writeback stalled for 5 cycles
        v = mkLoad(3'b011, 64'hA000_0048, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 2, 1);
        v.skip = 1'b1;
        applyStimulus(v, lat, busy);
        checkOutput("skip latency", lat, 2);
        checkOutput("skip read addr", rd_log[0], 64'hA000_0048);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("stall%0d resp_valid", k), resp_valid, 1'b1);
            checkOutput($sformatf("stall%0d resp_data", k), resp_data, 64'h0123_4567_89AB_CDEF);
            checkOutput($sformatf("stall%0d resp_skip_ref", k), resp_skip_ref, 1'b1);
            checkOutput($sformatf("stall%0d req_ready", k), req_ready, 1'b0);
            checkOutput($sformatf("stall%0d mem_en", k), mem_en, 1'b0);
        end
        releaseResp("skip", 1, 0);

        // The next op starts with a clean skip flag
        v = mkLoad(3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h1122_3344_5566_7788, 2, 1);
        applyStimulus(v, lat, busy);
        checkOutput("after-skip resp_skip_ref", resp_skip_ref, 1'b0);
        checkOutput("after-skip resp_data", resp_data, 64'h1122_3344_5566_7788);
        releaseResp("after-skip", 1, 0);

        // Reset in the middle of a store
        tb_skip = 1'b0; n_rd = 0; n_wr = 0;
        req_wen = 1'b1; req_funct3 = 3'b011; req_wdata = 64'h0807_0605_0403_0201;
`ifdef YSYX_22050518_LSU_MISALIGN_EN
        req_addr = 64'h8000_000C; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
`else
        req_addr = 64'h8000_0008; req_valid = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = 1'b0;
`endif
        @(negedge clk);
        checkOutput("abort mem_en", mem_en, 1'b0);
        checkOutput("abort mem_w_en", mem_w_en, 1'b0);
        checkOutput("abort req_ready", req_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort resp_valid", resp_valid, 1'b0);
        checkOutput("abort req_ready after release", req_ready, 1'b1);
`ifdef YSYX_22050518_LSU_MISALIGN_EN
        checkOutput("abort write count", n_wr, 1);
        checkOutput("abort write0 addr", wa_log[0], 64'h8000_000C);
        checkOutput("abort write0 width", ww_log[0], 4'd4);
`else
        checkOutput("abort write count", n_wr, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
